// File: rtl/axis_latency_monitor.sv
// AXI-Stream sink that checks packet routing/sequence, counts packets per source
// and keeps head-beat latency statistics, with LFSR-driven backpressure.
module axis_latency_monitor #(
   parameter int TDATA_WIDTH = 32,
   parameter int TDEST_WIDTH = 2,
   parameter int TID_WIDTH   = 2,
   parameter int TDEST       = 0,
   parameter int COUNT_WIDTH = 16,
   parameter int SUM_WIDTH   = 32,
   parameter logic [15:0] READY_SEED = 16'hACE1
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [TDATA_WIDTH/2-1:0]                      ticks,
   input  logic                                          enable,
   input  logic [7:0]                                    stall_threshold,
   input  logic                                          axis_in_tvalid,
   output logic                                          axis_in_tready,
   input  logic [TDATA_WIDTH-1:0]                        axis_in_tdata,
   input  logic                                          axis_in_tlast,
   input  logic [TID_WIDTH-1:0]                          axis_in_tid,
   input  logic [TDEST_WIDTH-1:0]                        axis_in_tdest,
   output logic [2**TID_WIDTH-1:0][COUNT_WIDTH-1:0]      recv_packets,
   output logic [TDATA_WIDTH/2-1:0]                      lat_min,
   output logic [TDATA_WIDTH/2-1:0]                      lat_max,
   output logic [SUM_WIDTH-1:0]                          lat_sum,
   output logic                                          error,
   output logic [1:0]                                    error_code
);

   localparam int TW = TDATA_WIDTH / 2;
   localparam logic [TDEST_WIDTH-1:0] OWN_DEST = TDEST_WIDTH'(TDEST);

   typedef enum logic {HEAD, BODY} state_t;

   state_t                                  state;
   logic [15:0]                             lfsr;
   logic [TID_WIDTH-1:0]                    cur_tid;
   logic [2**TID_WIDTH-1:0][COUNT_WIDTH-1:0] expected_seq;

   logic                   accept;
   logic                   head_accept;
   logic [TW-1:0]          head_ts;
   logic [COUNT_WIDTH-1:0] head_seq;
   logic [TW-1:0]          head_lat;
   logic                   dest_bad;
   logic                   seq_bad;
   logic                   tid_bad;
   logic [SUM_WIDTH:0]     sum_ext;
   logic                   lfsr_fb;

   assign accept      = axis_in_tvalid && axis_in_tready;
   assign head_accept = accept && (state == HEAD);
   assign head_ts     = axis_in_tdata[TW-1:0];
   assign head_seq    = axis_in_tdata[TW +: COUNT_WIDTH];
   // Modular subtraction keeps latency correct across a ticks wrap.
   assign head_lat    = ticks - head_ts;
   assign dest_bad    = head_accept && (axis_in_tdest != OWN_DEST);
   assign seq_bad     = head_accept && (head_seq != expected_seq[axis_in_tid]);
   assign tid_bad     = accept && (state == BODY) && (axis_in_tid != cur_tid);
   assign sum_ext     = {1'b0, lat_sum} + {{(SUM_WIDTH + 1 - TW){1'b0}}, head_lat};
   assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= HEAD;
         lfsr           <= READY_SEED;
         axis_in_tready <= 1'b0;
         cur_tid        <= '0;
         expected_seq   <= '0;
         recv_packets   <= '0;
         lat_min        <= '1;
         lat_max        <= '0;
         lat_sum        <= '0;
         error          <= 1'b0;
         error_code     <= 2'd0;
      end else begin
         lfsr           <= {lfsr[14:0], lfsr_fb};
         axis_in_tready <= enable && (lfsr[7:0] >= stall_threshold);

         if (accept) begin
            case (state)
               HEAD: begin
                  if (!axis_in_tlast) begin
                     state   <= BODY;
                     cur_tid <= axis_in_tid;
                  end
                  // Resynchronise to whatever arrived so one gap reports once.
                  expected_seq[axis_in_tid] <= head_seq + COUNT_WIDTH'(1);
                  if (head_lat < lat_min) lat_min <= head_lat;
                  if (head_lat > lat_max) lat_max <= head_lat;
                  lat_sum <= sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
               end
               BODY: begin
                  if (axis_in_tlast) state <= HEAD;
               end
               default: state <= HEAD;
            endcase
            if (axis_in_tlast)
               recv_packets[axis_in_tid] <= recv_packets[axis_in_tid] + COUNT_WIDTH'(1);
         end

         // Only the first fault is recorded; tdest outranks sequence.
         if (!error && (dest_bad || seq_bad || tid_bad)) begin
            error      <= 1'b1;
            error_code <= dest_bad ? 2'd1 : (seq_bad ? 2'd2 : 2'd3);
         end
      end
   end

endmodule

// File: tb/tb_axis_latency_monitor.sv
// Self-checking bench for axis_latency_monitor: directed scenarios plus a randomized
// backpressure run, all compared against a packet-level reference model.
module tb_axis_latency_monitor;

   localparam int TDW = 32;
   localparam int TW  = 16;
   localparam int CW  = 16;
   localparam int SW  = 32;
   localparam int NT  = 4;

   logic                      clk;
   logic                      rst_n;
   logic [TW-1:0]             ticks;
   logic                      enable;
   logic [7:0]                stall_threshold;
   logic                      axis_in_tvalid;
   logic                      axis_in_tready;
   logic [TDW-1:0]            axis_in_tdata;
   logic                      axis_in_tlast;
   logic [1:0]                axis_in_tid;
   logic [1:0]                axis_in_tdest;
   logic [NT-1:0][CW-1:0]     recv_packets;
   logic [TW-1:0]             lat_min;
   logic [TW-1:0]             lat_max;
   logic [SW-1:0]             lat_sum;
   logic                      error;
   logic [1:0]                error_code;

   axis_latency_monitor #(
      .TDATA_WIDTH(TDW), .TDEST_WIDTH(2), .TID_WIDTH(2), .TDEST(0),
      .COUNT_WIDTH(CW), .SUM_WIDTH(SW), .READY_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(enable),
      .stall_threshold(stall_threshold),
      .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
      .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
      .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
      .recv_packets(recv_packets), .lat_min(lat_min), .lat_max(lat_max),
      .lat_sum(lat_sum), .error(error), .error_code(error_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cycles = 0;
   bit tick_run = 0;

   // Reference model state, kept per packet rather than per register.
   longint mdl_cnt [NT];
   longint mdl_seq [NT];
   longint mdl_min;
   longint mdl_max;
   longint mdl_sum;
   int     mdl_err;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cycles++;
      if (tick_run) ticks = ticks + 16'd1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NT; i++) begin
         mdl_cnt[i] = 0;
         mdl_seq[i] = 0;
      end
      mdl_min = 64'hFFFF;
      mdl_max = 0;
      mdl_sum = 0;
      mdl_err = 0;
   endtask

   task automatic raise_error(input int code);
      if (mdl_err == 0) mdl_err = code;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      axis_in_tvalid = 1'b0;
      repeat (n) step();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic send_beat(input logic [1:0] tid, input logic [1:0] tdest, input logic [TDW-1:0] data,
                            input logic last, output bit ok, output logic [TW-1:0] acc_ticks);
      bit rdy;
      logic [TW-1:0] t;
      ok = 0;
      acc_ticks = '0;
      axis_in_tvalid = 1'b1;
      axis_in_tid = tid;
      axis_in_tdest = tdest;
      axis_in_tdata = data;
      axis_in_tlast = last;
      for (int c = 0; c < 200; c++) begin
         rdy = axis_in_tready;
         t = ticks;
         step();
         if (rdy) begin
            ok = 1;
            acc_ticks = t;
            break;
         end
      end
      axis_in_tvalid = 1'b0;
      if (!ok) check_output("accept_timeout", 64'd0, 64'd1);
   endtask

   // Sends one packet; bad_beat >= 1 replaces that beat's tid with bad_tid.
   task automatic apply_stimulus(input logic [1:0] tid, input logic [1:0] tdest, input logic [CW-1:0] seq,
                                 input logic [TW-1:0] ts, input int nbeats, input int bad_beat,
                                 input logic [1:0] bad_tid);
      bit ok;
      logic [TW-1:0] t;
      logic [1:0] btid;
      logic [TDW-1:0] data;
      longint lat;
      for (int b = 0; b < nbeats; b++) begin
         btid = (b == bad_beat) ? bad_tid : tid;
         data = (b == 0) ? {seq, ts} : TDW'($urandom);
         send_beat(btid, tdest, data, (b == nbeats - 1), ok, t);
         if (!ok) return;
         if (b == 0) begin
            lat = longint'(t - ts) & 64'hFFFF;
            if (tdest != 2'd0) raise_error(1);
            else if (longint'(seq) != mdl_seq[tid]) raise_error(2);
            mdl_seq[tid] = (longint'(seq) + 1) % 65536;
            if (lat < mdl_min) mdl_min = lat;
            if (lat > mdl_max) mdl_max = lat;
            mdl_sum = (mdl_sum + lat > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mdl_sum + lat;
         end else if (btid != tid) begin
            raise_error(3);
         end
         if (b == nbeats - 1) mdl_cnt[btid] = (mdl_cnt[btid] + 1) % 65536;
      end
   endtask

   task automatic check_all(input string tag);
      step();
      step();
      check_output({tag, "_error"}, 64'(error), (mdl_err != 0) ? 64'd1 : 64'd0);
      check_output({tag, "_code"}, 64'(error_code), 64'(mdl_err));
      check_output({tag, "_min"}, 64'(lat_min), 64'(mdl_min));
      check_output({tag, "_max"}, 64'(lat_max), 64'(mdl_max));
      check_output({tag, "_sum"}, 64'(lat_sum), 64'(mdl_sum));
      for (int i = 0; i < NT; i++)
         check_output($sformatf("%s_cnt%0d", tag, i), 64'(recv_packets[i]), 64'(mdl_cnt[i]));
   endtask

   initial begin
      bit ok;
      logic [TW-1:0] t;
      int rdy_cycles;
      int beats;
      int start;
      int nb;
      int tid_r;
      int pct;

      rst_n = 1'b0;
      ticks = '0;
      enable = 1'b1;
      stall_threshold = 8'd0;
      axis_in_tvalid = 1'b0;
      axis_in_tdata = '0;
      axis_in_tlast = 1'b0;
      axis_in_tid = '0;
      axis_in_tdest = '0;
      model_reset();

      // Reset held for five cycles.
      repeat (5) step();
      check_output("rst_tready", 64'(axis_in_tready), 64'd0);
      check_output("rst_lat_min", 64'(lat_min), 64'hFFFF);
      check_output("rst_error", 64'(error), 64'd0);
      for (int i = 0; i < NT; i++)
         check_output($sformatf("rst_cnt%0d", i), 64'(recv_packets[i]), 64'd0);
      rst_n = 1'b1;
      step();
      check_output("ready_after_reset", 64'(axis_in_tready), 64'd1);

      // Single-beat packet, latency 10.
      ticks = 16'd110;
      apply_stimulus(2'd1, 2'd0, 16'd0, 16'd100, 1, -1, 2'd0);
      check_all("single_beat");
      check_output("single_beat_lat10", 64'(lat_max), 64'd10);

      // Timestamp wrap: 0xFFFE -> 0x0003 is 5 ticks.
      ticks = 16'h0003;
      apply_stimulus(2'd1, 2'd0, 16'd1, 16'hFFFE, 1, -1, 2'd0);
      check_all("wrap");
      check_output("wrap_lat5", 64'(lat_min), 64'd5);

      // Sequence gap on tid 2, then resynchronised follow-up.
      ticks = 16'd500;
      apply_stimulus(2'd2, 2'd0, 16'd0, 16'd490, 2, -1, 2'd0);
      apply_stimulus(2'd2, 2'd0, 16'd2, 16'd480, 1, -1, 2'd0);
      check_all("seq_gap");
      check_output("seq_gap_code2", 64'(error_code), 64'd2);
      apply_stimulus(2'd2, 2'd0, 16'd3, 16'd400, 3, -1, 2'd0);
      check_all("seq_resync");
      check_output("seq_resync_cnt2", 64'(recv_packets[2]), 64'd3);

      // Wrong tdest and wrong seq on the same head beat.
      do_reset(2);
      ticks = 16'd50;
      apply_stimulus(2'd0, 2'd1, 16'd7, 16'd40, 1, -1, 2'd0);
      check_all("dest_prio");
      check_output("dest_prio_code1", 64'(error_code), 64'd1);

      // tid changes on beat 2 of a 3-beat packet.
      do_reset(2);
      apply_stimulus(2'd3, 2'd0, 16'd0, 16'd45, 3, 1, 2'd1);
      check_all("tid_change");
      check_output("tid_change_code3", 64'(error_code), 64'd3);

      // Reset in the middle of a packet leaves no trace.
      do_reset(2);
      send_beat(2'd0, 2'd0, {16'd0, 16'd20}, 1'b0, ok, t);
      do_reset(2);
      check_all("mid_reset");
      apply_stimulus(2'd0, 2'd0, 16'd0, 16'd30, 2, -1, 2'd0);
      check_all("after_mid_reset");

      // Disabled: tready drops and nothing is accepted.
      enable = 1'b0;
      step();
      check_output("disable_tready", 64'(axis_in_tready), 64'd0);
      axis_in_tvalid = 1'b1;
      axis_in_tlast = 1'b1;
      axis_in_tid = 2'd0;
      axis_in_tdata = {16'd1, 16'd30};
      rdy_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         if (axis_in_tready) rdy_cycles++;
         step();
      end
      axis_in_tvalid = 1'b0;
      check_output("disable_no_ready", 64'(rdy_cycles), 64'd0);
      enable = 1'b1;
      check_all("disable");

      // Randomized traffic under ~50% backpressure.
      do_reset(3);
      stall_threshold = 8'h80;
      tick_run = 1;
      beats = 0;
      start = cycles;
      while (cycles - start < 1000) begin
         tid_r = int'($urandom_range(0, 3));
         nb = int'($urandom_range(1, 3));
         apply_stimulus(2'(tid_r), 2'd0, CW'(mdl_seq[tid_r]),
                        ticks - TW'($urandom_range(0, 600)), nb, -1, 2'd0);
         beats += nb;
      end
      pct = (beats * 100) / (cycles - start);
      check_output("random_accept_ratio", ((pct >= 30) && (pct <= 70)) ? 64'd1 : 64'd0, 64'd1);
      check_all("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_latency_monitor.md
AXIS_LATENCY_MONITOR -- requirements
Module: axis_latency_monitor

Interface
REQ-001 SHALL have parameters: TDATA_WIDTH, default 32, data width; TDEST_WIDTH, default 2, destination ID width; TID_WIDTH, default 2, source ID width; TDEST, default 0, this endpoint's ID; COUNT_WIDTH, default 16, counter and sequence width (≤ TDATA_WIDTH/2); SUM_WIDTH, default 32, latency accumulator width; READY_SEED, default 16'hACE1, LFSR seed.
REQ-002 SHALL have port: clk  in  1  clock; reset rst_n, synchronous, active-low.
REQ-003 SHALL have port: ticks  in  TDATA_WIDTH/2  free-running timestamp.
REQ-004 SHALL have port: enable  in  1  allow acceptance.
REQ-005 SHALL have port: stall_threshold  in  8  backpressure level.
REQ-006 SHALL have ports: axis_in_tvalid in 1, axis_in_tready out 1, axis_in_tdata in TDATA_WIDTH, axis_in_tlast in 1, axis_in_tid in TID_WIDTH, axis_in_tdest in TDEST_WIDTH; AXI-Stream sink.
REQ-007 SHALL have port: recv_packets  out  [2**TID_WIDTH] x COUNT_WIDTH  per-source packet count.
REQ-008 SHALL have ports: lat_min out TDATA_WIDTH/2, lat_max out TDATA_WIDTH/2, lat_sum out SUM_WIDTH; head-beat latency statistics.
REQ-009 SHALL have ports: error out 1, sticky flag; error_code out 2, first error cause.

Function
REQ-010 SHALL accept a beat only in a cycle where tvalid and tready are both 1.
REQ-011 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle after reset.
REQ-012 SHALL register tready <= enable && (lfsr[7:0] >= stall_threshold); threshold 0 means always ready while enabled.
REQ-013 SHALL treat the head beat format as: tdata[TDATA_WIDTH/2-1:0] = injection timestamp, tdata[TDATA_WIDTH/2+COUNT_WIDTH-1:TDATA_WIDTH/2] = per-source sequence number.
REQ-014 SHALL use a two-state FSM. HEAD: accepted beat with tlast=0 latches tid and moves to BODY; with tlast=1 stays in HEAD. BODY: accepted beat with tlast=1 returns to HEAD.
REQ-015 SHALL, on a HEAD accept, compare tdest with TDEST and sequence with expected_seq[tid], then set expected_seq[tid] <= received sequence + 1 (resynchronise, modulo 2^COUNT_WIDTH).
REQ-016 SHALL, on a BODY accept, flag a mid-packet tid change if tid differs from the latched tid; body data content is not checked.
REQ-017 SHALL increment recv_packets[tid] modulo 2^COUNT_WIDTH on every accepted beat with tlast=1.
REQ-018 SHALL compute head latency = ticks - timestamp modulo 2^(TDATA_WIDTH/2), so counter wrap-around is handled.
REQ-019 SHALL update lat_min, lat_max and lat_sum one cycle after the head accept; lat_sum saturates at all-ones.
REQ-020 SHALL use error_code 1 = tdest mismatch, 2 = sequence mismatch, 3 = tid change mid-packet.
REQ-021 SHALL give tdest mismatch priority over sequence mismatch when both occur on the same beat.
REQ-022 SHALL set error and error_code on the cycle after the offending accept and hold them until reset; later errors do not change error_code.
REQ-023 SHALL keep the FSM, counters and statistics running after an error.
REQ-024 SHALL accept no beats while enable=0 (tready drops on the following cycle); the FSM holds its state.

Reset
REQ-025 SHALL reset, while rst_n=0 at a clk edge: tready 0; FSM HEAD; LFSR READY_SEED; all recv_packets 0; all expected_seq 0; lat_min all-ones; lat_max 0; lat_sum 0; error 0; error_code 0.
REQ-026 SHALL, on reset asserted mid-packet, discard the partial packet and leave no count or error from it.

Verification
REQ-027 SHALL cover: reset held for 5 cycles -> tready=0, lat_min=16'hFFFF, all counts 0, error=0.
REQ-028 SHALL cover: single-beat packet, tid=1, tdest=TDEST, seq=0, timestamp=100, accepted at ticks=110 -> recv_packets[1]=1, lat_min=lat_max=lat_sum=10, error=0.
REQ-029 SHALL cover: timestamp=16'hFFFE accepted at ticks=16'h0003 -> latency 5.
REQ-030 SHALL cover: tid=2 seq 0 then seq 2 -> error=1, error_code=2; a following seq 3 raises no new error and recv_packets[2]=3.
REQ-031 SHALL cover: head beat with wrong tdest and wrong seq -> error_code=1; a 3-beat packet whose tid changes on beat 2 (fresh reset) -> error_code=3.
REQ-032 SHALL cover: stall_threshold=8'h80 with tvalid held high for 1000 cycles -> roughly 50% acceptance, no beat lost or duplicated, counts match beats sent.
